// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single-port video RAM of the mini-VGA card between scanout
//   fetches and CPU writes coming from the Z80 I/O decoder. It holds the
//   CPU write pointer, buffers CPU data writes in a small FIFO and runs a
//   hardware screen-clear sequencer. Scanout always owns the RAM in the
//   cycle it asks; clear and CPU traffic fill the remaining cycles.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   cfg_valid     one-cycle strobe for a CPU register write
//   cfg_reg       0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL
//   cfg_data      CPU write byte
//   fetch_req     scanout wants the byte at fetch_addr this cycle
//   fetch_addr    scanout byte address
//   fetch_data    scanout byte, qualified by fetch_valid
//   fetch_valid   high one cycle after the matching fetch_req
//   ram_addr      RAM address (holds its last value when the RAM is idle)
//   ram_wdata     RAM write data
//   ram_we        RAM write enable
//   ram_rdata     RAM read data, one-cycle synchronous read
//   busy          clear running or CPU writes still buffered
//   overflow      sticky flag: a DATA write was dropped on a full FIFO

module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int VRAM_BYTES = 38400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_reg,
    input  logic [7:0]        cfg_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_data,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              overflow
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VRAM_BYTES - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] hi_ptr;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        fill_val;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        last_wdata;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W:0]    count;

    logic              fifo_empty;
    logic              fifo_full;
    logic              cfg_data_wr;
    logic              cfg_ctrl_wr;
    logic              clear_slot;
    logic              clear_start;
    logic              pop;
    logic              push;
    logic              drop;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_COUNT);
    assign cfg_data_wr = cfg_valid && (cfg_reg == 2'd2);
    assign cfg_ctrl_wr = cfg_valid && (cfg_reg == 2'd3);

    // Slot ownership: scanout first, then the clear sequencer, then the FIFO.
    // The FIFO is frozen while a clear runs so later writes land on top of it.
    assign clear_slot  = !fetch_req && (state == CLEAR);
    assign pop         = !fetch_req && (state == IDLE) && !fifo_empty;
    assign push        = cfg_data_wr && (!fifo_full || pop);
    assign drop        = cfg_data_wr && fifo_full && !pop;
    assign clear_start = cfg_ctrl_wr && cfg_data[0] && (state == IDLE);

    assign busy        = (state == CLEAR) || !fifo_empty;
    assign fetch_data  = fetch_valid ? ram_rdata : 8'h00;

    // ADDR_HI candidate pointer; out-of-range values snap back to zero.
    always_comb begin
        hi_ptr            = ptr;
        hi_ptr[ADDR_W-1:8] = (ADDR_W - 8)'(cfg_data);
    end

    // Next-state logic: the clear ends on the cycle its final byte is issued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_start) state_next = CLEAR;
            CLEAR:   if (clear_slot && (clr_cnt == LAST_ADDR)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM port mux; when nobody uses the slot the address and data just hold.
    always_comb begin
        ram_addr  = last_addr;
        ram_wdata = last_wdata;
        ram_we    = 1'b0;
        if (fetch_req) begin
            ram_addr = fetch_addr;
        end else if (state == CLEAR) begin
            ram_addr  = clr_cnt;
            ram_wdata = fill_val;
            ram_we    = 1'b1;
        end else if (!fifo_empty) begin
            ram_addr  = fifo_addr[rd_idx];
            ram_wdata = fifo_data[rd_idx];
            ram_we    = 1'b1;
        end
    end

    // FIFO payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= ptr;
            fifo_data[wr_idx] <= cfg_data;
        end
    end

    // Control state: FSM, pointer, FIFO bookkeeping, flags and held RAM bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            clr_cnt     <= '0;
            fill_val    <= 8'h00;
            rd_idx      <= '0;
            wr_idx      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            fetch_valid <= 1'b0;
            last_addr   <= '0;
            last_wdata  <= 8'h00;
        end else begin
            state       <= state_next;
            fetch_valid <= fetch_req;
            last_addr   <= ram_addr;
            last_wdata  <= ram_wdata;

            if (clear_start) begin
                clr_cnt  <= '0;
                fill_val <= cfg_data[7] ? 8'hFF : 8'h00;
            end else if (clear_slot) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end

            if (push) wr_idx <= wr_idx + PTR_W'(1);
            if (pop)  rd_idx <= rd_idx + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (pop && !push) count <= count - (PTR_W + 1)'(1);

            if (cfg_valid) begin
                case (cfg_reg)
                    2'd0: ptr[7:0] <= cfg_data;
                    2'd1: ptr <= (hi_ptr > LAST_ADDR) ? '0 : hi_ptr;
                    2'd2: if (push) ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
                    default: ;
                endcase
            end

            if (drop)                            overflow <= 1'b1;
            else if (cfg_ctrl_wr && cfg_data[1]) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter. A byte-array RAM model sits on the
//   RAM port. A transaction-level reference model (queue of pending CPU
//   writes, clear progress counter and a golden RAM image) predicts every
//   cycle's RAM traffic and flags, and a vector table plus hand sequences
//   cover register behaviour, overflow, full-FIFO push/pop, clear and reset.

module tb_vram_arbiter;

    localparam int VRAM  = 38400;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [1:0]  cfg_reg;
    logic [7:0]  cfg_data;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic        fetch_valid;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        busy;
    logic        overflow;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  gold [0:65535];

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        mq[$];
    int         mPtr;
    bit         mClearing;
    int         mClrIdx;
    logic [7:0] mFill;
    bit         mOvf;
    bit         mPrevFetch;
    logic [7:0] mPrevFetchData;
    int         mLastAddr;

    typedef struct {
        logic        v;
        logic [1:0]  r;
        logic [7:0]  d;
        logic        fr;
        logic [15:0] fa;
        logic        eBusy;
        logic        eOvf;
    } vec_t;

    vec_t vecs[26];

    vram_arbiter #(.ADDR_W(16), .VRAM_BYTES(VRAM), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_reg    (cfg_reg),
        .cfg_data   (cfg_data),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Single-port synchronous RAM preloaded with a recognisable pattern.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pattern(i);
        forever begin
            @(posedge clk);
            if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Hard stop in case something hangs beyond every bounded loop.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got hang expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mPtr           = 0;
        mClearing      = 0;
        mClrIdx        = 0;
        mFill          = 8'h00;
        mOvf           = 0;
        mPrevFetch     = 0;
        mPrevFetchData = 8'h00;
        mLastAddr      = 0;
    endtask

    // Predict this cycle's outputs from the rules, compare, then advance the
    // model across the coming clock edge using the current inputs.
    task automatic modelStep();
        bit  wasClearing;
        wr_t h;
        wr_t e;
        int  v;
        wasClearing = mClearing;

        checkOutput("busy", 32'(busy), 32'(mClearing || (mq.size() != 0)));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("fetch_valid", 32'(fetch_valid), 32'(mPrevFetch));
        if (mPrevFetch) checkOutput("fetch_data", 32'(fetch_data), 32'(mPrevFetchData));

        if (fetch_req) begin
            checkOutput("fetch_route_addr", 32'(ram_addr), 32'(fetch_addr));
            checkOutput("fetch_no_we", 32'(ram_we), 32'(0));
            mPrevFetchData = gold[fetch_addr];
            mLastAddr      = int'(fetch_addr);
        end else if (mClearing) begin
            checkOutput("clear_we", 32'(ram_we), 32'(1));
            checkOutput("clear_addr", 32'(ram_addr), 32'(mClrIdx));
            checkOutput("clear_data", 32'(ram_wdata), 32'(mFill));
            gold[mClrIdx] = mFill;
            mLastAddr     = mClrIdx;
            if (mClrIdx == VRAM - 1) mClearing = 0;
            else                     mClrIdx++;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            checkOutput("cpu_we", 32'(ram_we), 32'(1));
            checkOutput("cpu_addr", 32'(ram_addr), 32'(h.addr));
            checkOutput("cpu_data", 32'(ram_wdata), 32'(h.data));
            gold[h.addr] = h.data;
            mLastAddr    = int'(h.addr);
        end else begin
            checkOutput("idle_we", 32'(ram_we), 32'(0));
            checkOutput("idle_addr_hold", 32'(ram_addr), 32'(mLastAddr));
        end
        mPrevFetch = fetch_req;

        if (rst) begin
            modelReset();
        end else if (cfg_valid) begin
            case (cfg_reg)
                2'd0: mPtr = (mPtr & 32'hFF00) | int'(cfg_data);
                2'd1: begin
                    v    = int'(cfg_data) * 256 + (mPtr & 255);
                    mPtr = (v >= VRAM) ? 0 : v;
                end
                2'd2: begin
                    if (mq.size() < DEPTH) begin
                        e.addr = 16'(mPtr);
                        e.data = cfg_data;
                        mq.push_back(e);
                        mPtr = (mPtr == VRAM - 1) ? 0 : mPtr + 1;
                    end else begin
                        mOvf = 1;
                    end
                end
                default: begin
                    if (cfg_data[1]) mOvf = 0;
                    if (cfg_data[0] && !wasClearing) begin
                        mClearing = 1;
                        mClrIdx   = 0;
                        mFill     = cfg_data[7] ? 8'hFF : 8'h00;
                    end
                end
            endcase
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, pass the
    // rising edge and return shortly after it.
    task automatic applyStimulus(input logic v, input logic [1:0] r, input logic [7:0] d,
                                 input logic fr, input logic [15:0] fa, input logic rs);
        cfg_valid  = v;
        cfg_reg    = r;
        cfg_data   = d;
        fetch_req  = fr;
        fetch_addr = fa;
        rst        = rs;
        @(negedge clk);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(0));
        checkOutput({tag, "_fetch_valid"}, 32'(fetch_valid), 32'(0));
        checkOutput({tag, "_fetch_data"}, 32'(fetch_data), 32'(0));
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'(0));
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(0));
    endtask

    initial begin
        int n;
        int bad;
        int frPct;
        int sel;
        logic       rv;
        logic [1:0] rr;
        logic [7:0] rd;

        // {valid, reg, data, fetch_req, fetch_addr, busy after, overflow after}
        vecs[0]  = '{1'b1, 2'd0, 8'h34, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 8'h12, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 8'hAA, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'd2, 8'h55, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 8'h01, 1'b1, 16'h0100, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 8'h02, 1'b1, 16'h0100, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 8'h03, 1'b1, 16'h0100, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 8'h04, 1'b1, 16'h0100, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 8'h05, 1'b1, 16'h0100, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 16'h0100, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 2'd3, 8'h02, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 2'd1, 8'hFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 2'd2, 8'h11, 1'b1, 16'h0200, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 2'd2, 8'h12, 1'b1, 16'h0200, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 2'd2, 8'h13, 1'b1, 16'h0200, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 2'd2, 8'h14, 1'b1, 16'h0200, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 2'd2, 8'h15, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 65536; i++) gold[i] = pattern(i);
        modelReset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_reg = 2'd0; cfg_data = 8'h00;
        fetch_req = 1'b0; fetch_addr = 16'h0000;
        $display("[TB] starting vram_arbiter bench");

        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkAllZero("reset");

        $display("[TB] vector table: pointer, FIFO, overflow, full push+pop");
        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].fr, vecs[i].fa, 1'b0);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eBusy));
            checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eOvf));
        end
        checkOutput("ram_1234", 32'(mem[16'h1234]), 32'h0000_00AA);
        checkOutput("ram_1235", 32'(mem[16'h1235]), 32'h0000_0055);
        checkOutput("ram_1236", 32'(mem[16'h1236]), 32'h0000_0001);
        checkOutput("ram_1239", 32'(mem[16'h1239]), 32'h0000_0004);
        checkOutput("ram_123a_dropped", 32'(mem[16'h123A]), 32'(pattern(16'h123A)));
        checkOutput("ram_0003", 32'(mem[3]), 32'h0000_0014);
        checkOutput("ram_0004_fullpushpop", 32'(mem[4]), 32'h0000_0015);

        $display("[TB] pointer wrap at end of RAM");
        applyStimulus(1'b1, 2'd1, 8'h95, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h0F, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h0F, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'hEE, 1'b0, 16'h0000, 1'b0);
        idleCycles(4);
        checkOutput("wrap_last", 32'(mem[VRAM - 1]), 32'h0000_000F);
        checkOutput("wrap_zero", 32'(mem[0]), 32'h0000_000F);
        checkOutput("wrap_one", 32'(mem[1]), 32'h0000_00EE);

        $display("[TB] randomized traffic against reference model");
        frPct = 30;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) frPct = $urandom_range(10, 95);
            sel = $urandom_range(0, 19);
            rv  = ($urandom_range(0, 1) == 1);
            rd  = 8'($urandom_range(0, 255));
            if (sel < 12)      rr = 2'd2;
            else if (sel < 15) rr = 2'd0;
            else if (sel < 18) rr = 2'd1;
            else begin
                rr = 2'd3;
                rd = rd & 8'hFE;
            end
            applyStimulus(rv, rr, rd, ($urandom_range(0, 99) < frPct),
                          16'($urandom_range(0, VRAM - 1)), 1'b0);
        end
        applyStimulus(1'b1, 2'd3, 8'h02, 1'b0, 16'h0000, 1'b0);
        idleCycles(8);

        $display("[TB] hardware clear to 0xFF with periodic scanout");
        applyStimulus(1'b1, 2'd3, 8'h81, 1'b0, 16'h0000, 1'b0);
        n = 0;
        do begin
            applyStimulus(1'b0, 2'd0, 8'h00, ((n % 8) == 7),
                          16'($urandom_range(0, VRAM - 1)), 1'b0);
            n++;
        end while (busy && n < 46000);
        checkOutput("clear_finished_in_budget", 32'(n < 46000), 32'(1));
        checkOutput("clear_busy_low", 32'(busy), 32'(0));
        bad = 0;
        for (int i = 0; i < VRAM; i++) if (mem[i] !== 8'hFF) bad++;
        checkOutput("clear_all_ff", 32'(bad), 32'(0));
        checkOutput("clear_stops_at_end", 32'(mem[VRAM]), 32'(pattern(VRAM)));

        $display("[TB] reset in the middle of a clear with writes buffered");
        applyStimulus(1'b1, 2'd3, 8'h01, 1'b0, 16'h0000, 1'b0);
        idleCycles(10);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 2'd2, 8'(8'hC0 + i), 1'b0, 16'h0000, 1'b0);
        checkOutput("midclear_overflow", 32'(overflow), 32'(1));
        idleCycles(50);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 16'd20000, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkAllZero("midclear_reset");
        idleCycles(20);
        checkOutput("midclear_head_cleared", 32'(mem[0]), 32'h0000_0000);
        checkOutput("midclear_tail_untouched", 32'(mem[1000]), 32'h0000_00FF);
        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== gold[i]) bad++;
        checkOutput("ram_image_vs_model", 32'(bad), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
